stddev_norm: RTL and testbench

Computes the window standard deviation used for Haar-feature threshold normalisation, from the window pixel sum and squared-pixel sum taken from the integral images. It forms the scaled variance N·Σx² − (Σx)² and range-reduces it by even shifts to an 8-bit address. It then looks up the 256-entry `sqrt_rom` (driving its `ena`/`addra`, consuming its `doa`) and denormalises the result. It sits between the integral-image window fetch and the stage-threshold comparator.

---
 rtl/cascade_pkg.sv | 22 ++
 rtl/stddev_norm.sv | 112 +++++++++++
 tb/tb_stddev_norm.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cascade_pkg.sv
// Shared types and widths for the cascade evaluator: stddev FSM states and datapath sizes.
package cascade_pkg;

   localparam int W_SUM   = 18;
   localparam int W_SQSUM = 26;
   localparam int N       = 576;
   localparam int W_VAR   = 36;
   localparam int W_ROM   = 11;
   localparam int K_MAX   = (W_VAR - 8) / 2;
   localparam int W_K     = 4;
   localparam int W_OUT   = W_ROM + K_MAX;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      NORM = 3'd2,
      ROM  = 3'd3,
      WAIT = 3'd4,
      OUT  = 3'd5
   } stddev_state_t;

endpackage

// File: rtl/stddev_norm.sv
// Window stddev for Haar threshold normalisation: sqrt(N*sqsum - sum^2)*128 via an external sqrt ROM.
// Latency 5+k cycles (k = even-shift count, 0..14); one transaction in flight, OUT holds until dout_ready.
module stddev_norm
   import cascade_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               din_valid,
   output logic               din_ready,
   input  logic [W_SUM-1:0]   din_sum,
   input  logic [W_SQSUM-1:0] din_sqsum,
   output logic               rom_ena,
   output logic [7:0]         rom_addr,
   input  logic [W_ROM-1:0]   rom_data,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic [W_OUT-1:0]   dout
);

   stddev_state_t      state_q, state_d;
   logic [W_SUM-1:0]   sum_q, sum_d;
   logic [W_SQSUM-1:0] sqsum_q, sqsum_d;
   logic [W_VAR-1:0]   var_q, var_d;
   logic [W_K-1:0]     k_q, k_d;
   logic [7:0]         rom_addr_q, rom_addr_d;
   logic [W_OUT-1:0]   dout_q, dout_d;

   // One extra bit so the difference's sign survives; both products fit below 2^W_VAR.
   logic [W_VAR:0]     prod;
   logic [W_VAR:0]     sq;
   logic [W_VAR:0]     diff;
   logic               var_fits;

   assign prod     = (W_VAR+1)'(N) * (W_VAR+1)'(sqsum_q);
   assign sq       = (W_VAR+1)'(sum_q) * (W_VAR+1)'(sum_q);
   assign diff     = prod - sq;
   assign var_fits = (var_q[W_VAR-1:8] == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         sum_q      <= '0;
         sqsum_q    <= '0;
         var_q      <= '0;
         k_q        <= '0;
         rom_addr_q <= '0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         sqsum_q    <= sqsum_d;
         var_q      <= var_d;
         k_q        <= k_d;
         rom_addr_q <= rom_addr_d;
         dout_q     <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (din_valid) state_d = CALC;
         CALC:    state_d = NORM;
         NORM:    if (var_fits) state_d = ROM;
         ROM:     state_d = WAIT;
         WAIT:    state_d = OUT;
         OUT:     if (dout_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sum_d      = sum_q;
      sqsum_d    = sqsum_q;
      var_d      = var_q;
      k_d        = k_q;
      rom_addr_d = rom_addr_q;
      dout_d     = dout_q;
      case (state_q)
         IDLE: begin
            if (din_valid) begin
               sum_d   = din_sum;
               sqsum_d = din_sqsum;
            end
         end
         CALC: begin
            var_d = diff[W_VAR] ? '0 : diff[W_VAR-1:0];
            k_d   = '0;
         end
         NORM: begin
            // Address is loaded on the way out so it is valid for the whole ROM cycle.
            if (var_fits) begin
               rom_addr_d = var_q[7:0];
            end else begin
               var_d = var_q >> 2;
               k_d   = k_q + W_K'(1);
            end
         end
         WAIT:    dout_d = W_OUT'(rom_data) << k_q;
         default: ;
      endcase
   end

   always_comb begin
      din_ready  = (state_q == IDLE);
      rom_ena    = (state_q == ROM);
      dout_valid = (state_q == OUT);
      rom_addr   = rom_addr_q;
      dout       = dout_q;
   end

endmodule

// File: tb/tb_stddev_norm.sv
// Bench for stddev_norm: registered sqrt ROM model plus an arithmetic reference of the window stddev.
module tb_stddev_norm;
   import cascade_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               din_valid = 1'b0;
   logic               din_ready;
   logic [W_SUM-1:0]   din_sum = '0;
   logic [W_SQSUM-1:0] din_sqsum = '0;
   logic               rom_ena;
   logic [7:0]         rom_addr;
   logic [W_ROM-1:0]   rom_data = '0;
   logic               dout_valid;
   logic               dout_ready = 1'b0;
   logic [W_OUT-1:0]   dout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [W_ROM-1:0] rom_img [256];

   stddev_norm dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din_sum    (din_sum),
      .din_sqsum  (din_sqsum),
      .rom_ena    (rom_ena),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout       (dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rom_ena) rom_data <= rom_img[rom_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   // Reference: plain integer arithmetic, reduce by factors of four until it fits the ROM.
   task automatic model(input logic [W_SUM-1:0] s, input logic [W_SQSUM-1:0] q,
                        output logic [W_OUT-1:0] d, output int k, output logic [7:0] a);
      longint v;
      longint e;
      v = longint'(N) * longint'(q) - longint'(s) * longint'(s);
      if (v < 0) v = 0;
      k = 0;
      while (v > 255) begin
         v = v / 4;
         k++;
      end
      a = 8'(v);
      e = longint'(rom_img[a]) * (longint'(1) << k);
      d = W_OUT'(e);
   endtask

   function automatic logic [W_SUM-1:0] rnd_sum();
      return W_SUM'($urandom) >> $urandom_range(0, W_SUM - 1);
   endfunction

   function automatic logic [W_SQSUM-1:0] rnd_sqsum();
      return W_SQSUM'($urandom) >> $urandom_range(0, W_SQSUM - 1);
   endfunction

   // Drives one transaction from a negedge in IDLE and returns what was observed.
   task automatic run_txn(input logic [W_SUM-1:0] s, input logic [W_SQSUM-1:0] q, input int hold,
                          output logic [W_OUT-1:0] got, output int lat, output int ena_cnt,
                          output logic [7:0] addr_seen, output logic stable_ok, output logic busy_ok);
      din_sum   = s;
      din_sqsum = q;
      din_valid = 1'b1;
      dout_ready = 1'b0;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din_sum   = rnd_sum();
      din_sqsum = rnd_sqsum();
      lat = 0;
      ena_cnt = 0;
      addr_seen = 'x;
      busy_ok = 1'b1;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (rom_ena) begin
            ena_cnt++;
            addr_seen = rom_addr;
         end
         if (din_ready) busy_ok = 1'b0;
         if (dout_valid) break;
      end
      got = dout;
      stable_ok = dout_valid;
      repeat (hold) begin
         @(negedge clk);
         if (dout !== got || !dout_valid || din_ready || rom_ena) stable_ok = 1'b0;
      end
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      dout_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b exp 1", din_ready); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", dout_valid); end
      checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %0d exp 0", dout); end
      checks++; if (rom_ena !== 1'b0) begin errors++; $display("FAIL reset_rom_ena got %b exp 0", rom_ena); end
      checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr got %0d exp 0", rom_addr); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [W_SUM-1:0]   ts [5] = '{18'd57600, 18'd0, 18'd1, 18'd0, 18'd1000};
      logic [W_SQSUM-1:0] tq [5] = '{26'd5760000, 26'd1, 26'd1, 26'h3FFFFFF, 26'd0};
      logic [W_OUT-1:0]   te [5] = '{25'd0, 25'd3072, 25'd3060, 25'd25067520, 25'd0};
      int                 tl [5] = '{5, 6, 6, 19, 5};
      logic [W_OUT-1:0] got, md;
      int lat, ena, mk;
      logic [7:0] addr, ma;
      logic stab, busy;
      for (int i = 0; i < 5; i++) begin
         run_txn(ts[i], tq[i], 0, got, lat, ena, addr, stab, busy);
         model(ts[i], tq[i], md, mk, ma);
         checks++; if (got !== te[i]) begin errors++; $display("FAIL dir%0d_dout got %0d exp %0d", i, got, te[i]); end
         checks++; if (got !== md) begin errors++; $display("FAIL dir%0d_dout_model got %0d exp %0d", i, got, md); end
         checks++; if (lat != tl[i]) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, tl[i]); end
         checks++; if (ena != 1) begin errors++; $display("FAIL dir%0d_rom_ena_cycles got %0d exp 1", i, ena); end
         checks++; if (addr !== ma) begin errors++; $display("FAIL dir%0d_rom_addr got %0d exp %0d", i, addr, ma); end
         checks++; if (!busy) begin errors++; $display("FAIL dir%0d_din_ready_busy got 1 exp 0", i); end
      end
      run_txn(18'd1000, 26'd0, 0, got, lat, ena, addr, stab, busy);
      checks++; if (addr !== 8'd0) begin errors++; $display("FAIL clamp_rom_addr got %0d exp 0", addr); end
   endtask

   task automatic test_random();
      logic [W_SUM-1:0] s;
      logic [W_SQSUM-1:0] q;
      logic [W_OUT-1:0] got, md;
      int lat, ena, mk, hold;
      logic [7:0] addr, ma;
      logic stab, busy;
      for (int i = 0; i < 30; i++) begin
         s = rnd_sum();
         q = rnd_sqsum();
         hold = $urandom_range(0, 3);
         model(s, q, md, mk, ma);
         run_txn(s, q, hold, got, lat, ena, addr, stab, busy);
         checks++; if (got !== md) begin errors++; $display("FAIL rnd%0d_dout s=%0d q=%0d got %0d exp %0d", i, s, q, got, md); end
         checks++; if (lat != 5 + mk) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, 5 + mk); end
         checks++; if (ena != 1) begin errors++; $display("FAIL rnd%0d_rom_ena_cycles got %0d exp 1", i, ena); end
         checks++; if (addr !== ma) begin errors++; $display("FAIL rnd%0d_rom_addr got %0d exp %0d", i, addr, ma); end
         checks++; if (!stab || !busy) begin errors++; $display("FAIL rnd%0d_hold stable=%b busy_ok=%b exp 1 1", i, stab, busy); end
      end
   endtask

   task automatic test_backpressure();
      logic [W_OUT-1:0] got, md;
      int lat, ena, mk;
      logic [7:0] addr, ma;
      logic stab, busy;
      model(18'd0, 26'd1, md, mk, ma);
      run_txn(18'd0, 26'd1, 3, got, lat, ena, addr, stab, busy);
      checks++; if (!stab) begin errors++; $display("FAIL bp_stable got 0 exp 1"); end
      checks++; if (!busy) begin errors++; $display("FAIL bp_din_ready got 1 exp 0"); end
      checks++; if (ena != 1) begin errors++; $display("FAIL bp_rom_ena_cycles got %0d exp 1", ena); end
      checks++; if (got !== md) begin errors++; $display("FAIL bp_dout got %0d exp %0d", got, md); end
   endtask

   task automatic test_back_to_back();
      logic [W_SUM-1:0] s [4];
      logic [W_SQSUM-1:0] q [4];
      logic [W_OUT-1:0] md [4];
      int mk [4];
      logic [7:0] ma;
      int t_prev, t_now, n;
      for (int i = 0; i < 4; i++) begin
         s[i] = rnd_sum();
         q[i] = rnd_sqsum();
         model(s[i], q[i], md[i], mk[i], ma);
      end
      dout_ready = 1'b1;
      din_sum = s[0];
      din_sqsum = q[0];
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      t_prev = cyc;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            din_sum = s[i + 1];
            din_sqsum = q[i + 1];
         end else begin
            din_valid = 1'b0;
         end
         n = 0;
         do begin @(negedge clk); n++; end while (!dout_valid && n < 40);
         checks++; if (!dout_valid) begin errors++; $display("FAIL b2b%0d_timeout dout_valid got 0 exp 1", i); end
         checks++; if (dout !== md[i]) begin errors++; $display("FAIL b2b%0d_dout got %0d exp %0d", i, dout, md[i]); end
         if (i < 3) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!din_ready && n < 40);
            @(posedge clk);
            #1;
            t_now = cyc;
            checks++;
            if (t_now - t_prev != 6 + mk[i]) begin
               errors++; $display("FAIL b2b%0d_period got %0d exp %0d", i, t_now - t_prev, 6 + mk[i]);
            end
            t_prev = t_now;
         end
      end
      @(posedge clk);
      #1;
      dout_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [W_SUM-1:0] s;
      logic [W_SQSUM-1:0] q;
      logic [W_OUT-1:0] got, md;
      int lat, ena, mk;
      logic [7:0] addr, ma;
      logic stab, busy, quiet;
      din_sum = '0;
      din_sqsum = 26'h3FFFFFF;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dout_valid got %b exp 0", dout_valid); end
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rstmid_din_ready got %b exp 1", din_ready); end
      checks++; if (rom_ena !== 1'b0) begin errors++; $display("FAIL rstmid_rom_ena got %b exp 0", rom_ena); end
      checks++; if (dout !== '0) begin errors++; $display("FAIL rstmid_dout got %0d exp 0", dout); end
      @(negedge clk);
      rst = 1'b1;
      quiet = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (rom_ena || dout_valid || !din_ready) quiet = 1'b0;
      end
      checks++; if (!quiet) begin errors++; $display("FAIL rstmid_abort_quiet got 0 exp 1"); end
      s = rnd_sum();
      q = rnd_sqsum();
      model(s, q, md, mk, ma);
      run_txn(s, q, 0, got, lat, ena, addr, stab, busy);
      checks++; if (got !== md) begin errors++; $display("FAIL rstmid_next_dout got %0d exp %0d", got, md); end
      checks++; if (lat != 5 + mk) begin errors++; $display("FAIL rstmid_next_latency got %0d exp %0d", lat, 5 + mk); end
   endtask

   initial begin
      // ROM image floor(sqrt(a)*128): gives 0x600 at 144 and 0x5FA at 143.
      for (int a = 0; a < 256; a++) rom_img[a] = W_ROM'(isqrt(a * 16384));
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
